irb_fmi_tile_agen: RTL and testbench

- Runtime-configurable address generator that streams FMI RAM read addresses for one input tile across a range of channels.
- Successor to the fixed 3x3 / stride-1 / 7x7 tiling used by the IRB datapath: kernel size, output tile size and stride (1 or 2) are generalised, and out-of-map positions are flagged as zero-padding.
- Sits between the IRB layer controller and the FMI RAM read port; feeds the expansion/DW stages via a valid/ready stream.

---
 rtl/irb_fmi_tile_agen.sv | 220 ++++++++++++++++++++++
 tb/tb_irb_fmi_tile_agen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/irb_fmi_tile_agen.sv
// FMI RAM read-address generator for one IRB input tile across a channel range.
// Optional stall counter on perf_stall when IRB_AGEN_PERF_EN is defined.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | streaming beats, out_valid high
//   S_DONE | one-cycle done pulse
module irb_fmi_tile_agen #(
   parameter int NKX    = 3,
   parameter int NKY    = 3,
   parameter int TOX    = 7,
   parameter int TOY    = 7,
   parameter int DIM_W  = 8,
   parameter int CH_W   = 11,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cfg_stride2,
   input  logic [DIM_W-1:0]  cfg_nix,
   input  logic [DIM_W-1:0]  cfg_niy,
   input  logic [CH_W-1:0]   cfg_ch_base,
   input  logic [CH_W-1:0]   cfg_nch,
   input  logic [DIM_W-1:0]  cfg_ox,
   input  logic [DIM_W-1:0]  cfg_oy,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_pad,
   output logic [DIM_W-1:0]  out_tx,
   output logic [DIM_W-1:0]  out_ty,
   output logic              out_last,
   output logic [31:0]       perf_stall
);

   localparam int SW = DIM_W + 2;
   localparam int HX = (NKX - 1) / 2;
   localparam int HY = (NKY - 1) / 2;
   localparam logic [DIM_W-1:0] TIX_S1 = DIM_W'(TOX - 1 + NKX);
   localparam logic [DIM_W-1:0] TIX_S2 = DIM_W'(2 * (TOX - 1) + NKX);
   localparam logic [DIM_W-1:0] TIY_S1 = DIM_W'(TOY - 1 + NKY);
   localparam logic [DIM_W-1:0] TIY_S2 = DIM_W'(2 * (TOY - 1) + NKY);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DIM_W-1:0]  nix_q, niy_q, tix_q, tiy_q;
   logic [CH_W-1:0]   nch_q;
   logic [SW-1:0]     ix0_q, iy0_q;
   logic [ADDR_W-1:0] plane_q, row_off_q;
   logic [DIM_W-1:0]  tx_q, ty_q;
   logic [CH_W-1:0]   c_q;
   logic [SW-1:0]     ix_q, iy_q;
   logic [ADDR_W-1:0] row_q, chan_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              pad_q, pad_d, last_q, last_d;

   logic              load, fire, upd;
   logic [DIM_W-1:0]  k_nix, k_niy, k_tix, k_tiy;
   logic [CH_W-1:0]   k_nch;
   logic [SW-1:0]     s_ix0, s_iy0;
   logic [ADDR_W-1:0] s_plane, s_row_off, s_chan;
   logic [DIM_W-1:0]  nb_tx, nb_ty;
   logic [CH_W-1:0]   nb_c;
   logic [SW-1:0]     nb_ix, nb_iy;
   logic [ADDR_W-1:0] nb_row, nb_chan;

   function automatic logic [ADDR_W-1:0] sext(input logic [SW-1:0] v);
      return {{(ADDR_W-SW){v[SW-1]}}, v};
   endfunction

   always_comb begin
      load    = (state_q == S_IDLE) && start;
      fire    = (state_q == S_RUN) && out_ready;
      upd     = (load && (cfg_nch != '0)) || (fire && !last_q);
      state_d = state_q;

      // Start-time setup: the only multiplies; everything after is add-only.
      s_ix0     = (cfg_stride2 ? {1'b0, cfg_ox, 1'b0} : {2'b00, cfg_ox}) - SW'(HX);
      s_iy0     = (cfg_stride2 ? {1'b0, cfg_oy, 1'b0} : {2'b00, cfg_oy}) - SW'(HY);
      s_plane   = ADDR_W'(cfg_nix) * ADDR_W'(cfg_niy);
      s_row_off = sext(s_iy0) * ADDR_W'(cfg_nix);
      s_chan    = ADDR_W'(cfg_ch_base) * s_plane;

      k_nix = load ? cfg_nix : nix_q;
      k_niy = load ? cfg_niy : niy_q;
      k_tix = load ? (cfg_stride2 ? TIX_S2 : TIX_S1) : tix_q;
      k_tiy = load ? (cfg_stride2 ? TIY_S2 : TIY_S1) : tiy_q;
      k_nch = load ? cfg_nch : nch_q;

      nb_tx   = tx_q;
      nb_ty   = ty_q;
      nb_c    = c_q;
      nb_ix   = ix_q;
      nb_iy   = iy_q;
      nb_row  = row_q;
      nb_chan = chan_q;

      if (load) begin
         nb_tx   = '0;
         nb_ty   = '0;
         nb_c    = '0;
         nb_ix   = s_ix0;
         nb_iy   = s_iy0;
         nb_chan = s_chan;
         nb_row  = s_chan + s_row_off;
      end else if (fire && !last_q) begin
         if (tx_q == tix_q - DIM_W'(1)) begin
            nb_tx = '0;
            nb_ix = ix0_q;
            if (ty_q == tiy_q - DIM_W'(1)) begin
               nb_ty   = '0;
               nb_iy   = iy0_q;
               nb_c    = c_q + CH_W'(1);
               nb_chan = chan_q + plane_q;
               nb_row  = chan_q + plane_q + row_off_q;
            end else begin
               nb_ty  = ty_q + DIM_W'(1);
               nb_iy  = iy_q + SW'(1);
               nb_row = row_q + ADDR_W'(nix_q);
            end
         end else begin
            nb_tx = tx_q + DIM_W'(1);
            nb_ix = ix_q + SW'(1);
         end
      end

      pad_d  = nb_ix[SW-1] || (nb_ix >= {2'b00, k_nix}) ||
               nb_iy[SW-1] || (nb_iy >= {2'b00, k_niy});
      addr_d = pad_d ? '0 : nb_row + sext(nb_ix);
      last_d = (nb_tx == k_tix - DIM_W'(1)) && (nb_ty == k_tiy - DIM_W'(1)) &&
               (nb_c == k_nch - CH_W'(1));

      case (state_q)
         S_IDLE:  if (load) state_d = (cfg_nch == '0) ? S_DONE : S_RUN;
         S_RUN:   if (fire && last_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         nix_q     <= '0;
         niy_q     <= '0;
         tix_q     <= '0;
         tiy_q     <= '0;
         nch_q     <= '0;
         ix0_q     <= '0;
         iy0_q     <= '0;
         plane_q   <= '0;
         row_off_q <= '0;
         tx_q      <= '0;
         ty_q      <= '0;
         c_q       <= '0;
         ix_q      <= '0;
         iy_q      <= '0;
         row_q     <= '0;
         chan_q    <= '0;
         addr_q    <= '0;
         pad_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            nix_q     <= k_nix;
            niy_q     <= k_niy;
            tix_q     <= k_tix;
            tiy_q     <= k_tiy;
            nch_q     <= k_nch;
            ix0_q     <= s_ix0;
            iy0_q     <= s_iy0;
            plane_q   <= s_plane;
            row_off_q <= s_row_off;
         end
         if (upd) begin
            tx_q   <= nb_tx;
            ty_q   <= nb_ty;
            c_q    <= nb_c;
            ix_q   <= nb_ix;
            iy_q   <= nb_iy;
            row_q  <= nb_row;
            chan_q <= nb_chan;
            addr_q <= addr_d;
            pad_q  <= pad_d;
            last_q <= last_d;
         end
      end
   end

   // busy includes the start cycle itself so a zero-channel request still shows it.
   assign busy      = (state_q != S_IDLE) || start;
   assign done      = (state_q == S_DONE);
   assign out_valid = (state_q == S_RUN);
   assign out_addr  = addr_q;
   assign out_pad   = pad_q;
   assign out_tx    = tx_q;
   assign out_ty    = ty_q;
   assign out_last  = last_q;

`ifdef IRB_AGEN_PERF_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (load) begin
         stall_q <= '0;
      end else if ((state_q == S_RUN) && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end
   assign perf_stall = stall_q;
`else
   assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_irb_fmi_tile_agen.sv
// Randomised self-checking bench for irb_fmi_tile_agen against a loop-based tile model.
module tb_irb_fmi_tile_agen;
   localparam int NKX = 3, NKY = 3, TOX = 7, TOY = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cfg_stride2 = 1'b0;
   logic [7:0]  cfg_nix = '0, cfg_niy = '0, cfg_ox = '0, cfg_oy = '0;
   logic [10:0] cfg_ch_base = '0, cfg_nch = '0;
   logic        out_ready = 1'b1;
   logic        busy, done, out_valid, out_pad, out_last;
   logic [19:0] out_addr;
   logic [7:0]  out_tx, out_ty;
   logic [31:0] perf_stall;

   int n_chk = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];

   always #5 clk = ~clk;

   irb_fmi_tile_agen dut (
      .clk(clk), .rst(rst), .start(start), .cfg_stride2(cfg_stride2),
      .cfg_nix(cfg_nix), .cfg_niy(cfg_niy), .cfg_ch_base(cfg_ch_base), .cfg_nch(cfg_nch),
      .cfg_ox(cfg_ox), .cfg_oy(cfg_oy), .busy(busy), .done(done), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr), .out_pad(out_pad), .out_tx(out_tx),
      .out_ty(out_ty), .out_last(out_last), .perf_stall(perf_stall)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // beat layout: addr[37:18] pad[17] tx[16:9] ty[8:1] last[0]
   function automatic logic [63:0] pack(input logic [19:0] a, input logic p,
                                        input logic [7:0] tx, input logic [7:0] ty,
                                        input logic l);
      return {26'b0, a, p, tx, ty, l};
   endfunction

   function automatic void build(input bit s2, input int nix, input int niy, input int chb,
                                 input int nch, input int ox, input int oy);
      int s, tix, tiy, ix, iy;
      bit p, l;
      longint a;
      s   = s2 ? 2 : 1;
      tix = s * (TOX - 1) + NKX;
      tiy = s * (TOY - 1) + NKY;
      exp_q.delete();
      for (int c = 0; c < nch; c++)
         for (int ty = 0; ty < tiy; ty++)
            for (int tx = 0; tx < tix; tx++) begin
               ix = s * ox - (NKX - 1) / 2 + tx;
               iy = s * oy - (NKY - 1) / 2 + ty;
               p  = (ix < 0) || (ix >= nix) || (iy < 0) || (iy >= niy);
               a  = p ? 0 : ((longint'(chb + c) * nix * niy + iy * nix + ix) & 64'hFFFFF);
               l  = (c == nch - 1) && (ty == tiy - 1) && (tx == tix - 1);
               exp_q.push_back(pack(a[19:0], p, tx[7:0], ty[7:0], l));
            end
   endfunction

   function automatic logic pick_ready(input bit rnd);
      return rnd ? logic'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic check_rst_outs(input string tag);
      check(tag, {busy, done, out_valid, out_last, out_pad, out_addr, out_tx, out_ty, perf_stall}, '0);
   endtask

   task automatic run_req(input bit s2, input int nix, input int niy, input int chb,
                          input int nch, input int ox, input int oy, input bit rnd,
                          input int abort_at);
      int busy_cnt = 0, done_cnt = 0, vcyc = 0, stalls = 0, bi = 0;
      bit prev_stall = 0, fin = 0;
      logic [63:0] prev = '0, cur;
      build(s2, nix, niy, chb, nch, ox, oy);
      got_q.delete();
      @(posedge clk); #1;
      cfg_stride2 = s2; cfg_nix = nix[7:0]; cfg_niy = niy[7:0];
      cfg_ch_base = chb[10:0]; cfg_nch = nch[10:0]; cfg_ox = ox[7:0]; cfg_oy = oy[7:0];
      start = 1'b1;
      out_ready = pick_ready(rnd);
      @(negedge clk);
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      start = 1'b0;
      // garbage config after start must not matter
      cfg_nix = 8'($urandom); cfg_ch_base = 11'($urandom); cfg_ox = 8'($urandom);
      out_ready = pick_ready(rnd);
      for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
         @(negedge clk);
         cur = pack(out_addr, out_pad, out_tx, out_ty, out_last);
         if (cyc == 0) check("first_valid_latency", out_valid, nch != 0);
         if (abort_at >= 0 && bi == abort_at && out_valid) begin
            rst = 1'b1;
            #1 check_rst_outs("rst_midreq_outs");
            repeat (2) @(posedge clk);
            #1 check_rst_outs("rst_hold_outs");
            rst = 1'b0;
            return;
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (out_valid) begin
            vcyc++;
            if (prev_stall) check("hold_during_stall", cur, prev);
            if (out_ready) begin
               got_q.push_back(cur);
               if (bi < exp_q.size()) check("beat", cur, exp_q[bi]);
               else check("beat_overrun", bi, exp_q.size() - 1);
               bi++;
               prev_stall = 0;
            end else begin
               stalls++;
               prev_stall = 1;
               prev = cur;
            end
         end
         if (!busy) fin = 1;
         else begin
            @(posedge clk); #1;
            out_ready = pick_ready(rnd);
         end
      end
      check("timeout", fin, 1);
      check("beat_total", bi, exp_q.size());
      check("done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cnt, vcyc + 2);
`ifdef IRB_AGEN_PERF_EN
      check("perf_stall", perf_stall, stalls);
`else
      check("perf_stall", perf_stall, 0);
`endif
      out_ready = 1'b1;
   endtask

   initial begin
      #1 check_rst_outs("reset_outs");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_req(0, 7, 7, 0, 1, 0, 0, 0, -1);
      check("t1_b0_pad", got_q[0][17], 1);
      check("t1_b10_addr", got_q[10][37:18], 0);
      check("t1_b10_pad", got_q[10][17], 0);
      check("t1_b10_txty", got_q[10][16:1], 16'h0101);
      check("t1_b80_pad", got_q[80][17], 1);
      check("t1_b80_last", got_q[80][0], 1);

      run_req(1, 14, 14, 0, 1, 0, 0, 0, -1);
      check("t2_tx2ty1_addr", got_q[17][37:18], 1);
      check("t2_tx2ty1_pad", got_q[17][17], 0);
      check("t2_last_addr", got_q[224][37:18], 195);
      check("t2_last_flags", {got_q[224][17], got_q[224][0]}, 2'b01);

      run_req(0, 7, 7, 2, 2, 0, 0, 0, -1);
      check("t3_b91_addr", got_q[91][37:18], 147);
      check("t3_final_last", got_q[161][0], 1);

      run_req(0, 7, 7, 0, 1, 0, 0, 1, -1);
      run_req(1, 14, 14, 3, 2, 1, 2, 1, -1);

      run_req(0, 7, 7, 5, 0, 0, 0, 0, -1);

      for (int k = 0; k < 6; k++)
         run_req(1'($urandom_range(0, 1)), $urandom_range(1, 30), $urandom_range(1, 30),
                 $urandom_range(0, 1279), $urandom_range(1, 3), $urandom_range(0, 20),
                 $urandom_range(0, 20), 1, -1);

      run_req(0, 7, 7, 2, 2, 0, 0, 0, 40);
      run_req(1, 10, 12, 7, 1, 1, 3, 1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
